// File: rtl/seq_tracker.sv
// seq_tracker: decodes a one-hot rotating sequencer bus into position, step direction,
// per-direction lap counts and a sticky error flag. Optional net step counter is
// enabled by defining SEQ_TRACKER_NET_EN.
module seq_tracker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     srst,
    input  logic [WIDTH-1:0]         seq_in,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic [1:0]               dir,
    output logic                     step_valid,
    output logic [CNT_W-1:0]         laps_right,
    output logic [CNT_W-1:0]         laps_left,
    output logic                     err
`ifdef SEQ_TRACKER_NET_EN
    ,
    output logic [CNT_W-1:0]         net_pos
`endif
);
    localparam int PW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_l;
    logic             w_legal;
    logic             w_step_r;
    logic             w_step_l;
    logic [PW-1:0]    w_idx;

    assign w_r      = {r_prev[0], r_prev[WIDTH-1:1]};
    assign w_l      = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
    assign w_legal  = (seq_in != '0) && ((seq_in & (seq_in - 1'b1)) == '0);
    assign w_step_r = (r_state == TRACK) && (seq_in == w_r);
    assign w_step_l = (r_state == TRACK) && (seq_in == w_l);

    // binary index of the set bit; only meaningful when the word is legal
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (seq_in[i]) w_idx = PW'(i);
    end

    // tracking FSM with all outputs registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst || srst) begin
            r_state    <= IDLE;
            r_prev     <= {1'b1, {(WIDTH-1){1'b0}}};
            pos        <= PW'(WIDTH - 1);
            dir        <= 2'b00;
            step_valid <= 1'b0;
            laps_right <= '0;
            laps_left  <= '0;
            err        <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            if (!w_legal) begin
                dir     <= 2'b11;
                err     <= 1'b1;
                r_state <= FAULT;
            end else if (r_state != TRACK) begin
                r_prev  <= seq_in;
                pos     <= w_idx;
                dir     <= 2'b00;
                r_state <= TRACK;
            end else if (seq_in == r_prev) begin
                dir <= 2'b00;
            end else if (w_step_r) begin
                r_prev     <= seq_in;
                pos        <= w_idx;
                dir        <= 2'b01;
                step_valid <= 1'b1;
                if (r_prev[0] && laps_right != {CNT_W{1'b1}})
                    laps_right <= laps_right + CNT_W'(1);
            end else if (w_step_l) begin
                r_prev     <= seq_in;
                pos        <= w_idx;
                dir        <= 2'b10;
                step_valid <= 1'b1;
                if (r_prev[WIDTH-1] && laps_left != {CNT_W{1'b1}})
                    laps_left <= laps_left + CNT_W'(1);
            end else begin
                r_prev <= seq_in;
                pos    <= w_idx;
                dir    <= 2'b11;
                err    <= 1'b1;
            end
        end
    end

`ifdef SEQ_TRACKER_NET_EN
    // signed net displacement: right steps count up, left steps count down, wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst || srst)
            net_pos <= '0;
        else if (w_step_r)
            net_pos <= net_pos + CNT_W'(1);
        else if (w_step_l)
            net_pos <= net_pos - CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_seq_tracker.sv
// tb_seq_tracker: randomized and directed checks of seq_tracker against an index-arithmetic model
module tb_seq_tracker;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       srst = 1'b0;
    logic [7:0] seq_in = 8'h00;
    logic [2:0] pos;
    logic [1:0] dir;
    logic       step_valid;
    logic [7:0] laps_right;
    logic [7:0] laps_left;
    logic       err;
`ifdef SEQ_TRACKER_NET_EN
    logic [7:0] net_pos;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int m_mode = 0;
    int m_pos  = 7;
    int m_dir  = 0;
    int m_sv   = 0;
    int m_lr   = 0;
    int m_ll   = 0;
    int m_err  = 0;
    int m_net  = 0;

    seq_tracker #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .srst(srst), .seq_in(seq_in),
        .pos(pos), .dir(dir), .step_valid(step_valid),
        .laps_right(laps_right), .laps_left(laps_left), .err(err)
`ifdef SEQ_TRACKER_NET_EN
        , .net_pos(net_pos)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_pos = 7; m_dir = 0; m_sv = 0;
        m_lr = 0; m_ll = 0; m_err = 0; m_net = 0;
    endfunction

    // model in terms of positions: right is index-1 mod W, left is index+1 mod W
    function automatic void model_step(input logic [7:0] v);
        int k;
        k = 0;
        for (int i = 0; i < W; i++) if (v[i]) k = i;
        m_sv = 0;
        if ($countones(v) != 1) begin
            m_dir = 3; m_err = 1; m_mode = 2;
        end else if (m_mode != 1) begin
            m_pos = k; m_dir = 0; m_mode = 1;
        end else if (k == m_pos) begin
            m_dir = 0;
        end else if (k == (m_pos + W - 1) % W) begin
            if (m_pos == 0 && m_lr < 255) m_lr++;
            m_pos = k; m_dir = 1; m_sv = 1; m_net = (m_net + 1) & 255;
        end else if (k == (m_pos + 1) % W) begin
            if (m_pos == W - 1 && m_ll < 255) m_ll++;
            m_pos = k; m_dir = 2; m_sv = 1; m_net = (m_net + 255) & 255;
        end else begin
            m_pos = k; m_dir = 3; m_err = 1;
        end
    endfunction

    // advance the model on every edge and compare the DUT shortly after
    always @(posedge clk) begin
        if (rst || srst) model_reset();
        else model_step(seq_in);
        #1;
        chk("pos", int'(pos), m_pos);
        chk("dir", int'(dir), m_dir);
        chk("step_valid", int'(step_valid), m_sv);
        chk("laps_right", int'(laps_right), m_lr);
        chk("laps_left", int'(laps_left), m_ll);
        chk("err", int'(err), m_err);
`ifdef SEQ_TRACKER_NET_EN
        chk("net_pos", int'(net_pos), m_net);
`endif
    end

    task automatic step(input logic [7:0] v, input logic s);
        @(negedge clk);
        seq_in = v;
        srst = s;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] v;
        int r;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pos", int'(pos), 7);
        chk("rst_dir", int'(dir), 0);
        chk("rst_sv", int'(step_valid), 0);
        chk("rst_laps", int'(laps_right) + int'(laps_left), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        step(8'h80, 0); chk("t2_dir0", int'(dir), 0); chk("t2_pos0", int'(pos), 7);
        step(8'h40, 0); chk("t2_pos1", int'(pos), 6); chk("t2_dir1", int'(dir), 1);
        chk("t2_sv1", int'(step_valid), 1);
        step(8'h20, 0); chk("t2_pos2", int'(pos), 5); chk("t2_dir2", int'(dir), 1);

        step(8'h10, 0); step(8'h08, 0); step(8'h04, 0); step(8'h02, 0); step(8'h01, 0);
        step(8'h80, 0); chk("t3_rdir", int'(dir), 1); chk("t3_lr", int'(laps_right), 1);
        chk("t3_rpos", int'(pos), 7);
        step(8'h01, 0); chk("t3_ldir", int'(dir), 2); chk("t3_ll", int'(laps_left), 1);
        chk("t3_lpos", int'(pos), 0);

        step(8'h02, 0); step(8'h04, 0); step(8'h08, 0); step(8'h10, 0);
        step(8'h00, 0); chk("t4_err", int'(err), 1); chk("t4_dir", int'(dir), 3);
        chk("t4_pos", int'(pos), 4);
        step(8'h02, 0); chk("t4_rpos", int'(pos), 1); chk("t4_rdir", int'(dir), 0);
        chk("t4_rsv", int'(step_valid), 0);
        step(8'h01, 0); chk("t4_sdir", int'(dir), 1); chk("t4_serr", int'(err), 1);

        step(8'h00, 1);
        step(8'h80, 0);
        step(8'h08, 0); chk("t5_dir", int'(dir), 3); chk("t5_err", int'(err), 1);
        chk("t5_pos", int'(pos), 3);
        step(8'h08, 1); chk("t5_serr", int'(err), 0); chk("t5_spos", int'(pos), 7);
        step(8'h80, 0); step(8'h01, 0);
        chk("t5_pre_ll", int'(laps_left), 1);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_ll", int'(laps_left), 0);
        chk("arst_pos", int'(pos), 7);
        @(negedge clk);
        rst = 1'b0;

`ifdef SEQ_TRACKER_NET_EN
        step(8'h01, 0); step(8'h02, 0); step(8'h04, 0); step(8'h08, 0);
        chk("t6_net", int'(net_pos), 8'hFD);
`endif

        for (int i = 0; i < 260; i++) begin
            step(8'h01, 0);
            step(8'h80, 0);
        end
        chk("t6_lr_sat", int'(laps_right), 255);
        chk("t6_ll_sat", int'(laps_left), 255);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30) v = 8'(1 << ((m_pos + W - 1) % W));
            else if (r < 60) v = 8'(1 << ((m_pos + 1) % W));
            else if (r < 72) v = 8'(1 << m_pos);
            else if (r < 84) v = 8'(1 << $urandom_range(0, W - 1));
            else begin
                v = 8'($urandom);
                if ($countones(v) == 1) v = 8'h00;
            end
            step(v, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
